// File: rtl/countdown_timer.sv
// countdown_timer: mm:ss countdown at one tick per TICK_DIV clocks, with
// start/pause/resume, clear, alarm at expiry and auto-return after ALARM_TICKS.
module countdown_timer #(
  parameter int TICK_DIV    = 2_000_000,
  parameter int ALARM_TICKS = 10
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       set_mode,
  input  logic [6:0] set_min,
  input  logic [6:0] set_sec,
  input  logic       start_stop,
  input  logic       clear,
  output logic [6:0] cur_min,
  output logic [6:0] cur_sec,
  output logic [1:0] state,
  output logic       done_pulse,
  output logic       alarm
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ALARM_TICKS > 0) ? $clog2(ALARM_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [6:0]    min_q, min_d, sec_q, sec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic          done_q, done_d;
  logic          alarm_q, alarm_d;
  logic          start_q, clear_q;

  logic          start_e, clr_e, tick;
  logic [6:0]    nmin, nsec;

  // Edge detection, tick detection and the decremented mm:ss value
  always_comb begin
    start_e = start_stop & ~start_q;
    clr_e   = clear & ~clear_q;
    tick    = (presc_q == PW'(TICK_DIV - 1));
    nmin    = min_q;
    nsec    = sec_q;
    if (sec_q != 7'd0) begin
      nsec = sec_q - 7'd1;
    end else if (min_q != 7'd0) begin
      nsec = 7'd59;
      nmin = min_q - 7'd1;
    end
  end

  // Next-state logic: set_mode > clear edge > start edge > tick
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    presc_d = presc_q;
    acnt_d  = acnt_q;
    done_d  = 1'b0;
    if (set_mode) begin
      state_d = S_IDLE;
      min_d   = (set_min > 7'd59) ? 7'd59 : set_min;
      sec_d   = (set_sec > 7'd59) ? 7'd59 : set_sec;
      presc_d = '0;
      acnt_d  = '0;
    end else if (clr_e) begin
      state_d = S_IDLE;
      min_d   = 7'd0;
      sec_d   = 7'd0;
      presc_d = '0;
      acnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          presc_d = '0;
          acnt_d  = '0;
          if (start_e && (min_q != 7'd0 || sec_q != 7'd0)) state_d = S_RUN;
        end
        S_RUN: begin
          // A start edge pauses and drops any coincident tick; prescaler holds
          if (start_e) begin
            state_d = S_PAUSE;
          end else begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
              min_d = nmin;
              sec_d = nsec;
              if (nmin == 7'd0 && nsec == 7'd0) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                presc_d = '0;
                acnt_d  = '0;
              end
            end
          end
        end
        S_PAUSE: begin
          if (start_e) state_d = S_RUN;
        end
        default: begin  // S_DONE: alarm until ack or ALARM_TICKS ticks
          if (start_e) begin
            state_d = S_IDLE;
            presc_d = '0;
            acnt_d  = '0;
          end else begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
              if (acnt_q + AW'(1) >= AW'(ALARM_TICKS)) begin
                state_d = S_IDLE;
                presc_d = '0;
                acnt_d  = '0;
              end else begin
                acnt_d = acnt_q + AW'(1);
              end
            end
          end
        end
      endcase
    end
    alarm_d = (state_d == S_DONE);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      min_q   <= 7'd0;
      sec_q   <= 7'd0;
      presc_q <= '0;
      acnt_q  <= '0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
      start_q <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      presc_q <= presc_d;
      acnt_q  <= acnt_d;
      done_q  <= done_d;
      alarm_q <= alarm_d;
      start_q <= start_stop;
      clear_q <= clear;
    end
  end

  assign cur_min    = min_q;
  assign cur_sec    = sec_q;
  assign state      = state_q;
  assign done_pulse = done_q;
  assign alarm      = alarm_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer (TICK_DIV=4, ALARM_TICKS=3): stimulus queues
// expected outputs tagged with the cycle they are due; a monitor on the
// falling edge pops and compares them.
module tb_countdown_timer;
  localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11;

  logic       CLK = 1'b0;
  logic       RESETN, set_mode, start_stop, clear;
  logic [6:0] set_min, set_sec, cur_min, cur_sec;
  logic [1:0] state;
  logic       done_pulse, alarm;

  countdown_timer #(.TICK_DIV(4), .ALARM_TICKS(3)) dut (
    .CLK(CLK), .RESETN(RESETN), .set_mode(set_mode), .set_min(set_min),
    .set_sec(set_sec), .start_stop(start_stop), .clear(clear),
    .cur_min(cur_min), .cur_sec(cur_sec), .state(state),
    .done_pulse(done_pulse), .alarm(alarm)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         due;
    string      nm;
    logic [1:0] st;
    int         mn;
    int         sc;
    logic       al;
    logic       dp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic expect_at(input string nm, input int dly, input logic [1:0] st,
                           input int mn, input int sc, input logic al, input logic dp);
    exp_t e;
    e.due = cyc + dly; e.nm = nm; e.st = st; e.mn = mn; e.sc = sc; e.al = al; e.dp = dp;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Monitor: compare every queued expectation on its due cycle
  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.due < cyc || state !== e.st || cur_min !== 7'(e.mn) || cur_sec !== 7'(e.sc) ||
          alarm !== e.al || done_pulse !== e.dp) begin
        errors++;
        $display("FAIL %s @cyc%0d: got st=%0d %0d:%0d al=%b dp=%b, want st=%0d %0d:%0d al=%b dp=%b",
                 e.nm, cyc, state, cur_min, cur_sec, alarm, done_pulse,
                 e.st, e.mn, e.sc, e.al, e.dp);
      end
    end
  end

  initial begin
    RESETN = 1'b0; set_mode = 1'b0; start_stop = 1'b0; clear = 1'b0;
    set_min = '0; set_sec = '0;
    step(1);
    expect_at("reset", 1, IDLE, 0, 0, 0, 0);
    step(1);
    RESETN = 1'b1;

    // Load 00:02, run to DONE, let the alarm time out
    set_mode = 1'b1; set_sec = 7'd2;
    expect_at("load_0002", 1, IDLE, 0, 2, 0, 0);
    step(1);
    set_mode = 1'b0;
    step(1);
    start_stop = 1'b1;
    expect_at("start_run", 1, RUN, 0, 2, 0, 0);
    step(1);
    start_stop = 1'b0;
    expect_at("pre_tick1", 3, RUN, 0, 2, 0, 0);
    expect_at("tick1", 4, RUN, 0, 1, 0, 0);
    expect_at("pre_tick2", 7, RUN, 0, 1, 0, 0);
    expect_at("done_enter", 8, DONE, 0, 0, 1, 1);
    expect_at("done_pulse_1clk", 9, DONE, 0, 0, 1, 0);
    expect_at("alarm_held", 19, DONE, 0, 0, 1, 0);
    expect_at("alarm_timeout", 20, IDLE, 0, 0, 0, 0);
    step(21);

    // Load 01:00, tick to 00:59, pause with prescaler held, resume
    set_mode = 1'b1; set_min = 7'd1; set_sec = 7'd0;
    expect_at("load_0100", 1, IDLE, 1, 0, 0, 0);
    step(1);
    set_mode = 1'b0; start_stop = 1'b1;
    expect_at("start_0100", 1, RUN, 1, 0, 0, 0);
    step(1);
    start_stop = 1'b0;
    expect_at("borrow_min", 4, RUN, 0, 59, 0, 0);
    step(6);
    start_stop = 1'b1;
    expect_at("pause", 1, PAUSE, 0, 59, 0, 0);
    step(1);
    start_stop = 1'b0;
    for (int i = 1; i <= 20; i++) expect_at("pause_hold", i, PAUSE, 0, 59, 0, 0);
    step(20);
    start_stop = 1'b1;
    expect_at("resume", 1, RUN, 0, 59, 0, 0);
    step(1);
    start_stop = 1'b0;
    expect_at("resume_pre", 1, RUN, 0, 59, 0, 0);
    expect_at("resume_tick", 2, RUN, 0, 58, 0, 0);
    step(5);
    // Start edge on the tick cycle: pause wins, tick dropped, prescaler held
    start_stop = 1'b1;
    expect_at("pause_on_tick", 1, PAUSE, 0, 58, 0, 0);
    step(1);
    start_stop = 1'b0;
    step(1);
    start_stop = 1'b1;
    expect_at("resume2", 1, RUN, 0, 58, 0, 0);
    step(1);
    start_stop = 1'b0;
    expect_at("held_tick", 1, RUN, 0, 57, 0, 0);
    step(1);

    // Clear and start in the same cycle; start on 00:00 ignored
    set_mode = 1'b1; set_min = 7'd0; set_sec = 7'd5;
    expect_at("load_0005", 1, IDLE, 0, 5, 0, 0);
    step(1);
    set_mode = 1'b0; start_stop = 1'b1;
    expect_at("start_0005", 1, RUN, 0, 5, 0, 0);
    step(1);
    start_stop = 1'b0;
    step(1);
    start_stop = 1'b1; clear = 1'b1;
    expect_at("clear_beats_start", 1, IDLE, 0, 0, 0, 0);
    step(1);
    start_stop = 1'b0; clear = 1'b0;
    step(1);
    start_stop = 1'b1;
    expect_at("start_on_zero", 1, IDLE, 0, 0, 0, 0);
    expect_at("start_on_zero2", 2, IDLE, 0, 0, 0, 0);
    step(1);
    start_stop = 1'b0;
    step(2);

    // Acknowledge the alarm with a start edge
    set_mode = 1'b1; set_sec = 7'd1;
    step(1);
    set_mode = 1'b0; start_stop = 1'b1;
    expect_at("start_0001", 1, RUN, 0, 1, 0, 0);
    step(1);
    start_stop = 1'b0;
    expect_at("done_0001", 4, DONE, 0, 0, 1, 1);
    step(4);
    start_stop = 1'b1;
    expect_at("ack", 1, IDLE, 0, 0, 0, 0);
    step(1);
    start_stop = 1'b0;

    // Reset mid-run at 01:30
    set_mode = 1'b1; set_min = 7'd1; set_sec = 7'd30;
    expect_at("load_0130", 1, IDLE, 1, 30, 0, 0);
    step(1);
    set_mode = 1'b0; start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    expect_at("run_0129", 4, RUN, 1, 29, 0, 0);
    step(6);
    RESETN = 1'b0;
    expect_at("reset_midrun", 1, IDLE, 0, 0, 0, 0);
    step(1);
    RESETN = 1'b1;
    expect_at("after_reset", 4, IDLE, 0, 0, 0, 0);
    step(4);

    // Clamp and start edge ignored during set_mode
    set_mode = 1'b1; set_min = 7'd75; set_sec = 7'd99;
    expect_at("clamp", 1, IDLE, 59, 59, 0, 0);
    step(1);
    start_stop = 1'b1;
    expect_at("start_in_set", 1, IDLE, 59, 59, 0, 0);
    step(1);
    start_stop = 1'b0; set_mode = 1'b0;
    expect_at("after_set", 2, IDLE, 59, 59, 0, 0);
    step(3);

    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
